// File: rtl/modmul_pkg.sv
// Shared constants for the modular-multiplier flow-control shell.
package modmul_pkg;

    localparam int DATA_W         = 256;
    localparam int MODMUL_LATENCY = 29;

    // Bits needed to hold a counter ranging over 0..n inclusive.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/cb_sync_fifo.sv
// Synchronous FIFO with a registered output stage; a write into an empty FIFO
// appears on the output the cycle after the write edge (no fall-through).
module cb_sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         wr_en_i,
    input  logic [W-1:0] wr_data_i,
    input  logic         rd_en_i,
    output logic         rd_valid_o,
    output logic [W-1:0] rd_data_o,
    output logic         full_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic         out_valid_q, out_valid_d;
    logic [W-1:0] out_data_q, out_data_d;
    logic         mem_empty;
    logic         load_out;
    logic         bypass;
    logic         mem_we;
    logic [AW+1:0] level;

    assign mem_empty = (wr_ptr_q == rd_ptr_q);
    assign load_out  = !out_valid_q || rd_en_i;
    // With the memory empty, a write goes straight into the output register.
    assign bypass    = load_out && mem_empty && wr_en_i;
    assign mem_we    = wr_en_i && !bypass;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (load_out) begin
            if (!mem_empty) begin
                out_valid_d = 1'b1;
                out_data_d  = mem_q[rd_ptr_q[AW-1:0]];
                rd_ptr_d    = rd_ptr_q + PTR_ONE;
            end else if (wr_en_i) begin
                out_valid_d = 1'b1;
                out_data_d  = wr_data_i;
            end else begin
                out_valid_d = 1'b0;
            end
        end
        if (mem_we) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
    end

    assign level      = {1'b0, wr_ptr_q - rd_ptr_q} + {{(AW+1){1'b0}}, out_valid_q};
    assign full_o     = (level >= (AW+2)'(DEPTH));
    assign rd_valid_o = out_valid_q;
    assign rd_data_o  = out_data_q;

endmodule

// File: rtl/modmul_credit_buffer.sv
// Credit-based valid/ready shell around the fixed-latency modular multiplier.
// Define MODMUL_CB_OVERFLOW_CHK_EN to add the sticky err output and its checks.
module modmul_credit_buffer
    import modmul_pkg::*;
#(
    parameter int DEPTH   = 32,
    parameter int LATENCY = MODMUL_LATENCY,
    parameter int TAG_W   = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_x,
    input  logic [DATA_W-1:0] s_y,
    input  logic [TAG_W-1:0]  s_tag,
    output logic              mul_in_valid,
    output logic [DATA_W-1:0] mul_x,
    output logic [DATA_W-1:0] mul_y,
    input  logic              mul_out_valid,
    input  logic [DATA_W-1:0] mul_q,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_q,
    output logic [TAG_W-1:0]  m_tag
`ifdef MODMUL_CB_OVERFLOW_CHK_EN
    ,
    output logic              err
`endif
);

    localparam int CW = cnt_w(DEPTH);
    // Headroom above DEPTH so an overrun is representable rather than wrapping.
    localparam int IW = cnt_w(DEPTH + LATENCY);
    localparam logic [CW-1:0] CRED_MAX = CW'(DEPTH);
    localparam logic [CW-1:0] CRED_ONE = CW'(1);
    localparam logic [IW-1:0] INF_ONE  = IW'(1);

    logic [CW-1:0]     credits_q, credits_d;
    logic [IW-1:0]     inflight_q, inflight_d;
    logic              mul_in_valid_q;
    logic [DATA_W-1:0] mul_x_q, mul_y_q;
    logic              accept;
    logic              pop;
    logic              res_ok;
    logic [TAG_W-1:0]  tag_head;
    logic              res_full;

    assign s_ready = (credits_q != '0);
    assign accept  = s_valid && s_ready;
    assign pop     = m_valid && m_ready;
    // Results with nothing issued (e.g. launched before a reset) are discarded.
    assign res_ok  = mul_out_valid && (inflight_q != '0);

    always_comb begin
        credits_d = credits_q;
        case ({accept, pop})
            2'b10:   credits_d = credits_q - CRED_ONE;
            2'b01:   credits_d = credits_q + CRED_ONE;
            default: credits_d = credits_q;
        endcase
    end

    always_comb begin
        inflight_d = inflight_q;
        case ({mul_in_valid_q, res_ok})
            2'b10:   inflight_d = inflight_q + INF_ONE;
            2'b01:   inflight_d = inflight_q - INF_ONE;
            default: inflight_d = inflight_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            credits_q      <= CRED_MAX;
            inflight_q     <= '0;
            mul_in_valid_q <= 1'b0;
            mul_x_q        <= '0;
            mul_y_q        <= '0;
        end else begin
            credits_q      <= credits_d;
            inflight_q     <= inflight_d;
            mul_in_valid_q <= accept;
            if (accept) begin
                mul_x_q <= s_x;
                mul_y_q <= s_y;
            end
        end
    end

    assign mul_in_valid = mul_in_valid_q;
    assign mul_x        = mul_x_q;
    assign mul_y        = mul_y_q;

    // Fixed multiplier latency keeps results in issue order, so tags are a plain queue.
    cb_sync_fifo #(
        .W     (TAG_W),
        .DEPTH (DEPTH)
    ) u_tag_q (
        .clk_i      (clock),
        .rst_ni     (reset),
        .wr_en_i    (accept),
        .wr_data_i  (s_tag),
        .rd_en_i    (res_ok),
        .rd_valid_o (),
        .rd_data_o  (tag_head),
        .full_o     ()
    );

    cb_sync_fifo #(
        .W     (TAG_W + DATA_W),
        .DEPTH (DEPTH)
    ) u_res_q (
        .clk_i      (clock),
        .rst_ni     (reset),
        .wr_en_i    (res_ok),
        .wr_data_i  ({tag_head, mul_q}),
        .rd_en_i    (m_ready),
        .rd_valid_o (m_valid),
        .rd_data_o  ({m_tag, m_q}),
        .full_o     (res_full)
    );

`ifdef MODMUL_CB_OVERFLOW_CHK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if ((res_ok && res_full) ||
            (mul_out_valid && (inflight_q == '0)) ||
            (inflight_q > IW'(DEPTH))) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    logic unused_full;
    assign unused_full = res_full;
`endif

endmodule

// File: tb/tb_modmul_credit_buffer.sv
// Directed bench for modmul_credit_buffer with a behavioural X*Y mod p multiplier stub.
module tb_modmul_credit_buffer;

    localparam int DEPTH = 32;
    localparam int LAT   = 29;
    localparam int TAG_W = 8;
    localparam logic [255:0] P_MOD = (256'd1 << 255) - 256'd19;

    logic              clock = 1'b0;
    logic              reset;
    logic              s_valid;
    logic              s_ready;
    logic [255:0]      s_x, s_y;
    logic [TAG_W-1:0]  s_tag;
    logic              mul_in_valid;
    logic [255:0]      mul_x, mul_y;
    logic              mul_out_valid;
    logic [255:0]      mul_q;
    logic              m_valid;
    logic              m_ready;
    logic [255:0]      m_q;
    logic [TAG_W-1:0]  m_tag;
`ifdef MODMUL_CB_OVERFLOW_CHK_EN
    logic              err;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    modmul_credit_buffer #(
        .DEPTH   (DEPTH),
        .LATENCY (LAT),
        .TAG_W   (TAG_W)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_x           (s_x),
        .s_y           (s_y),
        .s_tag         (s_tag),
        .mul_in_valid  (mul_in_valid),
        .mul_x         (mul_x),
        .mul_y         (mul_y),
        .mul_out_valid (mul_out_valid),
        .mul_q         (mul_q),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_q           (m_q),
        .m_tag         (m_tag)
`ifdef MODMUL_CB_OVERFLOW_CHK_EN
        ,
        .err           (err)
`endif
    );

    // Multiplier stub: fixed latency, no reset, so pre-reset results still emerge.
    function automatic logic [255:0] modmul(input logic [255:0] x, input logic [255:0] y);
        logic [511:0] prod;
        prod = {256'b0, x} * {256'b0, y};
        prod = prod % {256'b0, P_MOD};
        return prod[255:0];
    endfunction

    logic [LAT-1:0] vpipe = '0;
    logic [255:0]   dpipe [LAT];
    logic           extra_pulse = 1'b0;

    always @(posedge clock) begin
        vpipe    <= {vpipe[LAT-2:0], mul_in_valid};
        dpipe[0] <= modmul(mul_x, mul_y);
        for (int k = 1; k < LAT; k++) dpipe[k] <= dpipe[k-1];
    end

    assign mul_out_valid = vpipe[LAT-1] | extra_pulse;
    assign mul_q         = extra_pulse ? 256'hDEAD : dpipe[LAT-1];

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [263:0] obs, input logic [263:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One isolated operation: checks result value, tag and latency, then pops it.
    task automatic send_one(input logic [255:0] x, input logic [255:0] y,
                            input logic [7:0] tag, input logic [255:0] expq);
        int n;
        s_x = x; s_y = y; s_tag = tag; s_valid = 1'b1; m_ready = 1'b1;
        check("one_s_ready", 264'(s_ready), 264'(1));
        tick;
        s_valid = 1'b0;
        n = 0;
        while (!m_valid && n < 100) begin
            tick;
            n++;
        end
        check("one_latency", 264'(n), 264'(LAT + 1));
        check("one_q", 264'(m_q), 264'(expq));
        check("one_tag", 264'(m_tag), 264'(tag));
        tick;
        check("one_popped", 264'(m_valid), 264'(0));
    endtask

    initial begin
        int n, acc, got, first, last, sent, drops, seen;
        bit acc_now;

        reset = 1'b0; s_valid = 1'b0; s_x = '0; s_y = '0; s_tag = '0; m_ready = 1'b0;
        repeat (3) tick;
        check("rst_s_ready", 264'(s_ready), 264'(1));
        check("rst_mul_in_valid", 264'(mul_in_valid), 264'(0));
        check("rst_mul_x", 264'(mul_x), 264'(0));
        check("rst_m_valid", 264'(m_valid), 264'(0));
        check("rst_m_q", 264'(m_q), 264'(0));
        check("rst_m_tag", 264'(m_tag), 264'(0));
`ifdef MODMUL_CB_OVERFLOW_CHK_EN
        check("rst_err", 264'(err), 264'(0));
`endif
        reset = 1'b1;
        tick;

        // Single op 2*3 with tag 0x05
        s_x = 256'd2; s_y = 256'd3; s_tag = 8'h05; s_valid = 1'b1; m_ready = 1'b1;
        check("single_s_ready", 264'(s_ready), 264'(1));
        tick;
        s_valid = 1'b0;
        check("single_issue", 264'(mul_in_valid), 264'(1));
        check("single_mul_x", 264'(mul_x), 264'(2));
        check("single_mul_y", 264'(mul_y), 264'(3));
        tick;
        check("single_issue_end", 264'(mul_in_valid), 264'(0));
        n = 1;
        while (!m_valid && n < 100) begin
            tick;
            n++;
        end
        check("single_latency", 264'(n), 264'(30));
        check("single_q", 264'(m_q), 264'(6));
        check("single_tag", 264'(m_tag), 264'(8'h05));
        tick;
        check("single_popped", 264'(m_valid), 264'(0));

        // Reduction boundaries: (p-1)^2 = 1, (p-1)*2 = p-2
        send_one(P_MOD - 256'd1, P_MOD - 256'd1, 8'hA1, 256'd1);
        send_one(P_MOD - 256'd1, 256'd2, 8'hA2, P_MOD - 256'd2);

        // Streaming: 100 back-to-back ops
        m_ready = 1'b1; got = 0; sent = 0; drops = 0; first = -1; last = -1;
        for (int cyc = 0; cyc < 300 && got < 100; cyc++) begin
            if (m_valid) begin
                check("stream_q", 264'(m_q), 264'((got + 1) * (got + 2)));
                check("stream_tag", 264'(m_tag), 264'(got));
                if (first < 0) first = cyc;
                last = cyc;
                got++;
            end
            if (sent < 100) begin
                s_valid = 1'b1; s_x = 256'(sent + 1); s_y = 256'(sent + 2); s_tag = 8'(sent);
                if (!s_ready) drops++;
            end else begin
                s_valid = 1'b0;
            end
            acc_now = s_valid && s_ready;
            tick;
            if (acc_now) sent++;
        end
        s_valid = 1'b0;
        check("stream_no_drop", 264'(drops), 264'(0));
        check("stream_count", 264'(got), 264'(100));
        check("stream_contiguous", 264'(last - first + 1), 264'(100));

        // Full: exactly DEPTH accepts with downstream stalled
        m_ready = 1'b0; s_valid = 1'b1; acc = 0;
        for (int i = 0; i < 40; i++) begin
            s_tag = 8'(i);
            if (s_ready) acc++;
            tick;
        end
        check("full_accepts", 264'(acc), 264'(32));
        check("full_s_ready_low", 264'(s_ready), 264'(0));
        check("full_m_valid", 264'(m_valid), 264'(1));
        m_ready = 1'b1;
        tick;
        m_ready = 1'b0;
        check("full_after_pop_ready", 264'(s_ready), 264'(1));
        tick;
        check("full_refilled", 264'(s_ready), 264'(0));
        s_valid = 1'b0;
        m_ready = 1'b1; got = 0; n = 0;
        while (got < 32 && n < 200) begin
            if (m_valid) got++;
            tick;
            n++;
        end
        check("full_drained", 264'(got), 264'(32));
        check("full_empty", 264'(m_valid), 264'(0));
        check("full_credits_back", 264'(dut.credits_q), 264'(32));

        // Simultaneous accept and pop with 5 buffered
        m_ready = 1'b0; s_valid = 1'b1;
        repeat (5) tick;
        s_valid = 1'b0;
        repeat (35) tick;
        check("simul_credits_before", 264'(dut.credits_q), 264'(27));
        s_valid = 1'b1; m_ready = 1'b1;
        check("simul_m_valid", 264'(m_valid), 264'(1));
        tick;
        s_valid = 1'b0; m_ready = 1'b0;
        check("simul_credits_after", 264'(dut.credits_q), 264'(27));
        repeat (35) tick;
        m_ready = 1'b1; got = 0; n = 0;
        while (m_valid && n < 50) begin
            got++;
            tick;
            n++;
        end
        check("simul_count", 264'(got), 264'(5));

        // Reset with 10 ops in flight
        m_ready = 1'b1; s_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            s_x = 256'(i + 3); s_y = 256'(7);
            tick;
        end
        s_valid = 1'b0;
        repeat (5) tick;
        reset = 1'b0;
        #1;
        check("midrst_s_ready", 264'(s_ready), 264'(1));
        check("midrst_mul_in_valid", 264'(mul_in_valid), 264'(0));
        check("midrst_mul_x", 264'(mul_x), 264'(0));
        check("midrst_m_valid", 264'(m_valid), 264'(0));
        check("midrst_m_q", 264'(m_q), 264'(0));
        check("midrst_credits", 264'(dut.credits_q), 264'(32));
        tick;
        tick;
        reset = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (m_valid) seen++;
            tick;
        end
        check("stale_dropped", 264'(seen), 264'(0));
`ifdef MODMUL_CB_OVERFLOW_CHK_EN
        check("stale_err", 264'(err), 264'(1));
`endif

        // Spurious result strobe with nothing in flight
        reset = 1'b0;
        tick;
        reset = 1'b1;
        tick;
`ifdef MODMUL_CB_OVERFLOW_CHK_EN
        check("spur_err_clear", 264'(err), 264'(0));
`endif
        extra_pulse = 1'b1;
        tick;
        extra_pulse = 1'b0;
`ifdef MODMUL_CB_OVERFLOW_CHK_EN
        check("spur_err_rise", 264'(err), 264'(1));
`endif
        check("spur_no_result", 264'(m_valid), 264'(0));
        repeat (10) tick;
`ifdef MODMUL_CB_OVERFLOW_CHK_EN
        check("spur_err_sticky", 264'(err), 264'(1));
`endif
        check("spur_still_empty", 264'(m_valid), 264'(0));
        send_one(256'd5, 256'd7, 8'h33, 256'd35);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
